// File: rtl/apb_gpio_pkg.sv
// Shared constants and types for the APB GPIO slave.
package apb_gpio_pkg;

    // Wait-state counter width; holds WAIT_STATES values 0..3.
    localparam int unsigned WAIT_CNT_W = 2;

    // Register byte offsets. Only address bits [4:2] are decoded.
    localparam logic [4:0] ADDR_DATA_IN    = 5'h00;
    localparam logic [4:0] ADDR_DATA_OUT   = 5'h04;
    localparam logic [4:0] ADDR_DIR        = 5'h08;
    localparam logic [4:0] ADDR_IRQ_EN     = 5'h0C;
    localparam logic [4:0] ADDR_IRQ_TYPE   = 5'h10;
    localparam logic [4:0] ADDR_IRQ_POL    = 5'h14;
    localparam logic [4:0] ADDR_IRQ_STATUS = 5'h18;

    // APB transfer FSM states.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/apb_gpio_slave_irq_detect.sv
// Input synchroniser and per-bit interrupt set detection for the GPIO pins.
module gpio_irq_detect #(
    parameter int unsigned GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    input  logic [GPIO_WIDTH-1:0] irq_type,
    input  logic [GPIO_WIDTH-1:0] irq_pol,
    output logic [GPIO_WIDTH-1:0] data_in,
    output logic [GPIO_WIDTH-1:0] set_vec
);

    logic [GPIO_WIDTH-1:0] sync1_q, sync1_d;
    logic [GPIO_WIDTH-1:0] sync2_q, sync2_d;
    logic [GPIO_WIDTH-1:0] prev_q,  prev_d;
    logic [GPIO_WIDTH-1:0] edge_set;
    logic [GPIO_WIDTH-1:0] level_set;

    // Next state for the two-flop synchroniser and the one-cycle history.
    always_comb begin
        sync1_d = gpio_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchroniser and history flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign data_in = sync2_q;

    // Per-bit set request: edge or level match selected by irq_type.
    always_comb begin
        edge_set  = (sync2_q & ~prev_q & irq_pol) | (~sync2_q & prev_q & ~irq_pol);
        level_set = ~(sync2_q ^ irq_pol);
        set_vec   = (irq_type & edge_set) | (~irq_type & level_set);
    end

endmodule

// File: rtl/apb_gpio_slave.sv
// APB slave GPIO controller: transfer FSM, register file, W1C status and IRQ.
module apb_gpio_slave
    import apb_gpio_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [31:0]           PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  IRQ,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

    apb_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic [GPIO_WIDTH-1:0] data_out_q,   data_out_d;
    logic [GPIO_WIDTH-1:0] dir_q,        dir_d;
    logic [GPIO_WIDTH-1:0] irq_en_q,     irq_en_d;
    logic [GPIO_WIDTH-1:0] irq_type_q,   irq_type_d;
    logic [GPIO_WIDTH-1:0] irq_pol_q,    irq_pol_d;
    logic [GPIO_WIDTH-1:0] irq_status_q, irq_status_d;

    logic [GPIO_WIDTH-1:0] data_in;
    logic [GPIO_WIDTH-1:0] set_vec;
    logic [GPIO_WIDTH-1:0] wdata;
    logic [GPIO_WIDTH-1:0] w1c_mask;
    logic [4:0]            reg_addr;
    logic [31:0]           rdata;
    logic                  pready;
    logic                  complete;
    logic                  unused_bits;

    assign reg_addr    = {PADDR[4:2], 2'b00};
    assign wdata       = PWDATA[GPIO_WIDTH-1:0];
    assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA};

    gpio_irq_detect #(
        .GPIO_WIDTH(GPIO_WIDTH)
    ) u_irq_detect (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .gpio_in  (gpio_in),
        .irq_type (irq_type_q),
        .irq_pol  (irq_pol_q),
        .data_in  (data_in),
        .set_vec  (set_vec)
    );

    // Transfer FSM next state, wait counter and completion strobe.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pready     = 1'b1;
        complete   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // PSEL with PENABLE already high has no setup phase and is ignored.
                if (PSEL && !PENABLE) begin
                    state_d    = ST_ACCESS;
                    wait_cnt_d = WAIT_LOAD;
                end
            end
            ST_ACCESS: begin
                pready = (wait_cnt_q == '0);
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (PENABLE && pready) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end else if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Register writes on completion; status takes new sets over W1C clears.
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        irq_type_d = irq_type_q;
        irq_pol_d  = irq_pol_q;
        w1c_mask   = '0;
        if (complete && PWRITE) begin
            case (reg_addr)
                ADDR_DATA_OUT:   data_out_d = wdata;
                ADDR_DIR:        dir_d      = wdata;
                ADDR_IRQ_EN:     irq_en_d   = wdata;
                ADDR_IRQ_TYPE:   irq_type_d = wdata;
                ADDR_IRQ_POL:    irq_pol_d  = wdata;
                ADDR_IRQ_STATUS: w1c_mask   = wdata;
                default:         ;
            endcase
        end
        irq_status_d = (irq_status_q & ~w1c_mask) | set_vec;
    end

    // Register file flops.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            data_out_q   <= '0;
            dir_q        <= '0;
            irq_en_q     <= '0;
            irq_type_q   <= '0;
            irq_pol_q    <= '0;
            irq_status_q <= '0;
        end else begin
            data_out_q   <= data_out_d;
            dir_q        <= dir_d;
            irq_en_q     <= irq_en_d;
            irq_type_q   <= irq_type_d;
            irq_pol_q    <= irq_pol_d;
            irq_status_q <= irq_status_d;
        end
    end

    // Read mux; unmapped offset and bits above GPIO_WIDTH read zero.
    always_comb begin
        rdata = '0;
        case (reg_addr)
            ADDR_DATA_IN:    rdata = 32'(data_in);
            ADDR_DATA_OUT:   rdata = 32'(data_out_q);
            ADDR_DIR:        rdata = 32'(dir_q);
            ADDR_IRQ_EN:     rdata = 32'(irq_en_q);
            ADDR_IRQ_TYPE:   rdata = 32'(irq_type_q);
            ADDR_IRQ_POL:    rdata = 32'(irq_pol_q);
            ADDR_IRQ_STATUS: rdata = 32'(irq_status_q);
            default:         rdata = '0;
        endcase
    end

    assign PRDATA   = (complete && !PWRITE) ? rdata : '0;
    assign PREADY   = pready;
    assign IRQ      = |(irq_status_q & irq_en_q);
    assign gpio_out = data_out_q;
    assign gpio_oe  = dir_q;

endmodule
